// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        f3_r;
  logic [4:0]        rd_r;
  logic              a_neg_r;
  logic              b_neg_r;
  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;

  // Launch-time decode of the incoming operation
  logic              is_div;
  logic              signed_a;
  logic              signed_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    is_div   = funct3[2];
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = signed_a & op_a[XLEN-1];
    b_neg    = signed_b & op_b[XLEN-1];
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
    if (div_zero)
      special_res = funct3[1] ? op_a : '1;
    else
      special_res = funct3[1] ? '0 : INT_MIN;
  end

  // One radix-2 step: hi/lo hold product halves (mul) or remainder/quotient (div)
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   next_hi;
  logic [XLEN-1:0]   next_lo;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ok    = !div_diff[XLEN];
    if (f3_r[2]) begin
      next_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      next_lo = {lo[XLEN-2:0], div_ok};
    end else begin
      next_hi = mul_sum[XLEN:1];
      next_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the values produced by the final step
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    product = {next_hi, next_lo};
    if (a_neg_r ^ b_neg_r)
      product = -product;
    if (f3_r[2]) begin
      if (f3_r[1])
        final_res = a_neg_r ? -next_hi : next_hi;
      else
        final_res = (a_neg_r ^ b_neg_r) ? -next_lo : next_lo;
    end else begin
      final_res = (f3_r[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      counter <= '0;
      f3_r    <= '0;
      rd_r    <= '0;
      a_neg_r <= 1'b0;
      b_neg_r <= 1'b0;
      operand <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            f3_r    <= funct3;
            rd_r    <= rd_in;
            a_neg_r <= a_neg;
            b_neg_r <= b_neg;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= special_res;
              rd_out <= rd_in;
            end else begin
              state   <= CALC;
              busy    <= 1'b1;
              counter <= '0;
              operand <= is_div ? mag_b : mag_a;
              hi      <= '0;
              lo      <= is_div ? mag_a : mag_b;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hi      <= next_hi;
            lo      <= next_lo;
            counter <= counter + 1'b1;
            if (counter == LAST) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= final_res;
              rd_out <= rd_r;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle k is the k-th cycle after the edge that samples start; sampled at negedge.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit special);
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    logic [31:0] res;
    logic [4:0]  rdo;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    res = 'x;
    rdo = 'x;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = k;
          res = result;
          rdo = rd_out;
        end
      end
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, busy_cnt, special ? 0 : 32);
    chk({tag, ".done_cycle"}, done_cyc, special ? 1 : 33);
    chk({tag, ".done_pulses"}, done_cnt, 1);
    chk({tag, ".result"}, res, exp);
    chk({tag, ".rd_out"}, {27'd0, rdo}, {27'd0, rd});
    chk({tag, ".result_held"}, result, exp);
  endtask

  initial begin
    int busy_last;
    int done_cnt;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.rd_out", {27'd0, rd_out}, 32'd0);
    reset = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 1'b0);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 1'b0);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 1'b0);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 1'b0);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0);
    run_op("divu",   3'b101, 32'd7,        32'd2,        5'd9,  32'd3,        1'b0);
    run_op("remu",   3'b111, 32'd7,        32'd2,        5'd10, 32'd1,        1'b0);
    run_op("div0",   3'b100, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1'b1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        5'd12, 32'd5,        1'b1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1'b1);
    run_op("mul_x0", 3'b000, 32'd6,        32'd7,        5'd0,  32'd42,       1'b0);

    // start pulse during CALC must be ignored
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        done_cnt++;
        chk("ignore.done_cycle", k, 33);
        chk("ignore.result", result, 32'd14);
        chk("ignore.rd_out", {27'd0, rd_out}, 32'd9);
      end
      if (k == 5) begin
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd1; start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      @(negedge clk);
    end
    chk("ignore.done_pulses", done_cnt, 1);

    // kill during CALC aborts without done and keeps result
    funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_last = 0;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_last = k;
      if (done) done_cnt++;
      if (k == 10) kill = 1'b1;
      if (k == 11) kill = 1'b0;
      @(negedge clk);
    end
    chk("kill.last_busy", busy_last, 10);
    chk("kill.done_pulses", done_cnt, 0);
    chk("kill.result_kept", result, 32'd14);
    chk("kill.rd_kept", {27'd0, rd_out}, 32'd9);
    run_op("after_kill", 3'b101, 32'd7, 32'd2, 5'd15, 32'd3, 1'b0);

    // kill together with start in IDLE: nothing launches
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd16; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    busy_last = 0;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_last = k;
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("killstart.busy", busy_last, 0);
    chk("killstart.done", done_cnt, 0);
    chk("killstart.result", result, 32'd3);

    // reset mid-multiply
    funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 21) begin
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        chk("rst_mid.done", {31'd0, done}, 32'd0);
        chk("rst_mid.result", result, 32'd0);
        chk("rst_mid.rd_out", {27'd0, rd_out}, 32'd0);
        reset = 1'b0;
      end
      if (done) done_cnt++;
      if (k == 20) begin
        chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
      end
      @(negedge clk);
    end
    chk("rst_mid.no_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
